my_pe_vec_quant: RTL and testbench

- Parametrised successor to the single-lane MAC processing element.
- Computes a LANES-wide signed dot product per beat and accumulates it over a vector delimited by first/last markers.
- On the last beat it requantizes the accumulator to OUT_WIDTH: scale multiply, rounding right shift, zero-point add, saturate.
- Sits between the operand fetch/buffer logic and the output writeback of the quantized inference datapath.
- Fully pipelined; accepts one beat per cycle.

---
 rtl/my_pe_pkg.sv | 31 +++
 rtl/my_requant.sv | 93 +++++++++
 rtl/my_pe_vec_quant.sv | 115 +++++++++++
 tb/tb_my_pe_vec_quant.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/my_pe_pkg.sv
// Shared widths and constant helpers for the quantized PE family.
package my_pe_pkg;

  localparam int LANES_D        = 4;
  localparam int DATA_WIDTH_D   = 8;
  localparam int RESULT_WIDTH_D = 32;
  localparam int SCALE_WIDTH_D  = 16;
  localparam int OUT_WIDTH_D    = 8;
  localparam int SHIFT_WIDTH    = 6;

  // Full-precision width of one lane product.
  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Width that holds the sum of all lane products without overflow.
  function automatic int sum_width(input int data_width, input int lanes);
    return 2 * data_width + $clog2(lanes);
  endfunction

  // Most negative value of an n-bit signed number.
  function automatic longint min_q(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

  // Most positive value of an n-bit signed number.
  function automatic longint max_q(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/my_requant.sv
// Requantizer: scale multiply, round-half-up shift, zero-point add, saturate.
// Two register stages; its own valid in/out so other PEs can reuse it.
module my_requant
  import my_pe_pkg::*;
#(
  parameter int RESULT_WIDTH = RESULT_WIDTH_D,
  parameter int SCALE_WIDTH  = SCALE_WIDTH_D,
  parameter int OUT_WIDTH    = OUT_WIDTH_D
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [RESULT_WIDTH-1:0] acc,
  input  logic        [SCALE_WIDTH-1:0]  scale,
  input  logic        [SHIFT_WIDTH-1:0]  shift,
  input  logic signed [OUT_WIDTH-1:0]    zero_point,
  output logic                           out_valid,
  output logic signed [OUT_WIDTH-1:0]    qout,
  output logic                           sat
);

  localparam int PW = RESULT_WIDTH + SCALE_WIDTH + 1;
  // Headroom for a rounding constant of up to 2^62 on top of the product.
  localparam int RW = ((PW > 64) ? PW : 64) + 2;
  localparam logic signed [RW-1:0] Q_MIN = RW'(min_q(OUT_WIDTH));
  localparam logic signed [RW-1:0] Q_MAX = RW'(max_q(OUT_WIDTH));

  logic                          v3;
  logic signed [PW-1:0]          p_q;
  logic        [SHIFT_WIDTH-1:0] shift_q;
  logic signed [OUT_WIDTH-1:0]   zp_q;

  logic signed [RW-1:0]          p_ext;
  logic signed [RW-1:0]          rnd;
  logic signed [RW-1:0]          rounded;
  logic signed [RW-1:0]          val;
  logic        [SHIFT_WIDTH-1:0] shift_m1;
  logic signed [OUT_WIDTH-1:0]   q_next;
  logic                          sat_next;

  // S3: full-width signed product of accumulator and unsigned scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3      <= 1'b0;
      p_q     <= '0;
      shift_q <= '0;
      zp_q    <= '0;
    end else begin
      v3 <= in_valid;
      if (in_valid) begin
        p_q     <= acc * $signed({1'b0, scale});
        shift_q <= shift;
        zp_q    <= zero_point;
      end
    end
  end

  assign p_ext    = RW'(p_q);
  assign shift_m1 = shift_q - SHIFT_WIDTH'(1);
  assign rnd      = RW'(1) << shift_m1;
  assign rounded  = (shift_q == '0) ? p_ext : ((p_ext + rnd) >>> shift_q);
  assign val      = rounded + RW'(zp_q);

  // Clamp to the signed output range and flag when it bites.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    q_next   = val[OUT_WIDTH-1:0];
    sat_next = 1'b0;
    if (val < Q_MIN) begin
      q_next   = Q_MIN[OUT_WIDTH-1:0];
      sat_next = 1'b1;
    end else if (val > Q_MAX) begin
      q_next   = Q_MAX[OUT_WIDTH-1:0];
      sat_next = 1'b1;
    end
  end

  // S4: publish result; qout/sat hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      qout      <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        qout <= q_next;
        sat  <= sat_next;
      end
    end
  end

endmodule

// File: rtl/my_pe_vec_quant.sv
// LANES-wide signed dot-product accumulator with per-vector requantization.
module my_pe_vec_quant
  import my_pe_pkg::*;
#(
  parameter int LANES        = LANES_D,
  parameter int DATA_WIDTH   = DATA_WIDTH_D,
  parameter int RESULT_WIDTH = RESULT_WIDTH_D,
  parameter int SCALE_WIDTH  = SCALE_WIDTH_D,
  parameter int OUT_WIDTH    = OUT_WIDTH_D
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             valid,
  input  logic                             first,
  input  logic                             last,
  input  logic [LANES*DATA_WIDTH-1:0]      ain,
  input  logic [LANES*DATA_WIDTH-1:0]      bin,
  input  logic [SCALE_WIDTH-1:0]           scale,
  input  logic [SHIFT_WIDTH-1:0]           shift,
  input  logic signed [OUT_WIDTH-1:0]      zero_point,
  output logic                             acc_valid,
  output logic signed [RESULT_WIDTH-1:0]   acc_out,
  output logic                             qvalid,
  output logic signed [OUT_WIDTH-1:0]      qout,
  output logic                             sat
);

  localparam int PW = prod_width(DATA_WIDTH);
  localparam int SW = sum_width(DATA_WIDTH, LANES);

  logic signed [PW-1:0]           prod_q [LANES];
  logic                           v1, f1, l1;
  logic [SCALE_WIDTH-1:0]         scale1, scale2;
  logic [SHIFT_WIDTH-1:0]         shift1, shift2;
  logic signed [OUT_WIDTH-1:0]    zp1, zp2;
  logic                           last2;
  logic signed [SW-1:0]           sum_w;
  logic signed [RESULT_WIDTH-1:0] sum;

  // S1: per-lane products and beat markers; requant settings captured on last.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the product bank is a handful of flops, not a RAM, so it is
      // reset like any other pipeline register.
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      v1     <= 1'b0;
      f1     <= 1'b0;
      l1     <= 1'b0;
      scale1 <= '0;
      shift1 <= '0;
      zp1    <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so each stage sees the previous
      // cycle's values regardless of statement order.
      for (int i = 0; i < LANES; i++)
        prod_q[i] <= $signed(ain[i*DATA_WIDTH +: DATA_WIDTH]) *
                     $signed(bin[i*DATA_WIDTH +: DATA_WIDTH]);
      v1 <= valid;
      f1 <= valid & first;
      l1 <= valid & last;
      if (valid && last) begin
        scale1 <= scale;
        shift1 <= shift;
        zp1    <= zero_point;
      end
    end
  end

  // Adder tree over the registered lane products.
  always_comb begin
    sum_w = '0;
    for (int i = 0; i < LANES; i++) sum_w = sum_w + SW'(prod_q[i]);
  end

  assign sum = RESULT_WIDTH'(sum_w);

  // S2: reload or accumulate (wrapping); forward requant settings with last.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_valid <= 1'b0;
      acc_out   <= '0;
      last2     <= 1'b0;
      scale2    <= '0;
      shift2    <= '0;
      zp2       <= '0;
    end else begin
      acc_valid <= v1;
      last2     <= v1 & l1;
      if (v1) acc_out <= f1 ? sum : acc_out + sum;
      if (v1 && l1) begin
        scale2 <= scale1;
        shift2 <= shift1;
        zp2    <= zp1;
      end
    end
  end

  my_requant #(
    .RESULT_WIDTH (RESULT_WIDTH),
    .SCALE_WIDTH  (SCALE_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH)
  ) u_requant (
    .clk        (aclk),
    .rst_n      (aresetn),
    .in_valid   (acc_valid & last2),
    .acc        (acc_out),
    .scale      (scale2),
    .shift      (shift2),
    .zero_point (zp2),
    .out_valid  (qvalid),
    .qout       (qout),
    .sat        (sat)
  );

endmodule

// File: tb/tb_my_pe_vec_quant.sv
// Scoreboard bench for my_pe_vec_quant: expectations queued at drive time,
// popped and compared (value and arrival cycle) when the DUT reports.
module tb_my_pe_vec_quant;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int RW    = 32;
  localparam int SW    = 16;
  localparam int OW    = 8;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic                   valid, first, last;
  logic [LANES*DW-1:0]    ain, bin;
  logic [SW-1:0]          scale;
  logic [5:0]             shift;
  logic signed [OW-1:0]   zero_point;
  logic                   acc_valid;
  logic signed [RW-1:0]   acc_out;
  logic                   qvalid;
  logic signed [OW-1:0]   qout;
  logic                   sat;

  my_pe_vec_quant dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .valid      (valid),
    .first      (first),
    .last       (last),
    .ain        (ain),
    .bin        (bin),
    .scale      (scale),
    .shift      (shift),
    .zero_point (zero_point),
    .acc_valid  (acc_valid),
    .acc_out    (acc_out),
    .qvalid     (qvalid),
    .qout       (qout),
    .sat        (sat)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    bit     sat;
    int     due;
  } exp_t;

  exp_t acc_q[$];
  exp_t q_q[$];
  exp_t e_acc, e_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [RW-1:0] macc = '0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference requantizer.
  function automatic void qmodel(input longint acc, input int sc, input int sh,
                                 input int zp, output longint q, output bit s);
    longint p, r, v;
    p = acc * longint'(sc);
    if (sh == 0) r = p;
    else r = (p + (64'sd1 <<< (sh - 1))) >>> sh;
    v = r + longint'(zp);
    s = 1'b1;
    if (v > 127) q = 127;
    else if (v < -128) q = -128;
    else begin
      q = v;
      s = 1'b0;
    end
  endfunction

  task automatic beat(input int a[LANES], input int b[LANES], input bit f,
                      input bit l, input int sc, input int sh, input int zp);
    longint s;
    longint q;
    bit     qs;
    exp_t   e;
    @(posedge aclk); #1;
    valid = 1'b1; first = f; last = l;
    scale = SW'(sc); shift = 6'(sh); zero_point = OW'(zp);
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      ain[i*DW +: DW] = DW'(a[i]);
      bin[i*DW +: DW] = DW'(b[i]);
      s += longint'(a[i]) * longint'(b[i]);
    end
    macc = f ? RW'(s) : macc + RW'(s);
    e.val = longint'(macc); e.sat = 1'b0; e.due = cyc + 2;
    acc_q.push_back(e);
    if (l) begin
      qmodel(longint'(macc), sc, sh, zp, q, qs);
      e.val = q; e.sat = qs; e.due = cyc + 4;
      q_q.push_back(e);
    end
  endtask

  // Bubbles carry junk on every other input; it must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
      valid = 1'b0;
      first = 1'($urandom); last = 1'($urandom);
      ain = $urandom; bin = $urandom;
      scale = SW'($urandom); shift = 6'($urandom);
    end
  endtask

  task automatic hit_reset();
    aresetn = 1'b0;
    valid   = 1'b0;
    #1;
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_qvalid", qvalid, 0);
    check("rst_qout", qout, 0);
    check("rst_sat", sat, 0);
    acc_q.delete();
    q_q.delete();
    macc = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  // Monitor: compare whatever the DUT reports against the queued expectations.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      if (acc_valid) begin
        if (acc_q.size() == 0) check("acc_unexpected", 1, 0);
        else begin
          e_acc = acc_q.pop_front();
          check("acc_val", acc_out, e_acc.val);
          check("acc_lat", cyc, e_acc.due);
        end
      end
      if (qvalid) begin
        if (q_q.size() == 0) check("q_unexpected", 1, 0);
        else begin
          e_q = q_q.pop_front();
          check("q_val", qout, e_q.val);
          check("q_sat", sat, e_q.sat);
          check("q_lat", cyc, e_q.due);
        end
      end
    end
  end

  initial begin
    int a[LANES];
    int b[LANES];
    int len, sc, sh, zp;
    valid = 1'b0; first = 1'b0; last = 1'b0;
    ain = '0; bin = '0; scale = '0; shift = '0; zero_point = '0;
    aresetn = 1'b1;
    #2;
    hit_reset();

    // One-beat vector, identity requant.
    beat('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1, 1, 1, 0, 0);
    idle(6);
    check("q_hold", qout, 70);

    // Two-beat vector with a gap; one qvalid only.
    beat('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1, 0, 1, 0, 0);
    idle(2);
    beat('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 1, 1, 0, 0);
    idle(6);

    // Rounding shift, negative rounding, zero point.
    beat('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1, 1, 3, 2, 0);
    beat('{-1, -2, -3, -4}, '{5, 6, 7, 8}, 1, 1, 3, 2, 0);
    beat('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1, 1, 3, 2, -5);
    idle(5);

    // Saturation both ways.
    beat('{127, 127, 127, 127}, '{127, 127, 127, 127}, 1, 1, 1, 0, 0);
    beat('{-128, -128, -128, -128}, '{127, 127, 127, 127}, 1, 1, 1, 0, 0);
    idle(5);

    // Back-to-back vectors with different settings.
    beat('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1, 1, 1, 0, 0);
    beat('{1, 1, 1, 1}, '{1, 2, 3, 4}, 1, 1, 2, 0, 0);
    idle(6);

    // Reset mid-vector: nothing in flight survives.
    beat('{1, 2, 3, 4}, '{5, 6, 7, 8}, 1, 0, 1, 0, 0);
    @(posedge aclk);
    hit_reset();
    idle(8);
    // first=0 straight after reset accumulates onto zero.
    beat('{1, 2, 3, 4}, '{1, 1, 1, 1}, 0, 1, 1, 0, 0);
    beat('{2, 2, 2, 2}, '{3, 3, 3, 3}, 1, 1, 1, 0, 0);
    idle(6);

    // Random vectors, random gaps and requant settings.
    for (int v = 0; v < 12; v++) begin
      len = $urandom_range(1, 4);
      sc  = $urandom_range(0, 65535);
      sh  = (v % 4 == 3) ? 63 : $urandom_range(0, 24);
      zp  = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < LANES; i++) begin
          a[i] = int'($urandom_range(0, 255)) - 128;
          b[i] = int'($urandom_range(0, 255)) - 128;
        end
        beat(a, b, k == 0, k == len - 1, sc, sh, zp);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end

    // Drain, bounded.
    for (int i = 0; i < 30 && (acc_q.size() != 0 || q_q.size() != 0); i++)
      idle(1);
    idle(2);
    check("drain_acc", acc_q.size(), 0);
    check("drain_q", q_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
